// File: rtl/tea_decipher.sv
// Iterative TEA decryption core: one full Feistel round per clock, ROUNDS cycles per block.
// Ciphertext and key are captured on an in_valid/in_ready handshake; plaintext is held on out_valid/out_ready.
module tea_decipher #(
  parameter int unsigned               WORD_SIZE = 32,
  parameter logic [WORD_SIZE-1:0]      DELTA     = 32'h9E3779B9,
  parameter int unsigned               ROUNDS    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] c0,
  input  logic [WORD_SIZE-1:0] c1,
  input  logic [WORD_SIZE-1:0] k0,
  input  logic [WORD_SIZE-1:0] k1,
  input  logic [WORD_SIZE-1:0] k2,
  input  logic [WORD_SIZE-1:0] k3,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] p0,
  output logic [WORD_SIZE-1:0] p1,
  output logic                 busy
);

  localparam int unsigned CNT_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ROUNDS - 1);
  localparam logic [2*WORD_SIZE-1:0] SUM_PROD =
    (2*WORD_SIZE)'(DELTA) * (2*WORD_SIZE)'(ROUNDS);
  localparam logic [WORD_SIZE-1:0] SUM_INIT = SUM_PROD[WORD_SIZE-1:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [WORD_SIZE-1:0]   y_q, y_d, z_q, z_d, sum_q, sum_d;
  logic [WORD_SIZE-1:0]   p0_q, p0_d, p1_q, p1_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WORD_SIZE-1:0]   k0_q, k1_q, k2_q, k3_q;
  logic [WORD_SIZE-1:0]   z_rnd, y_rnd;
  logic                   capture;

  function automatic logic [WORD_SIZE-1:0] tea_mix(
    input logic [WORD_SIZE-1:0] v,
    input logic [WORD_SIZE-1:0] ka,
    input logic [WORD_SIZE-1:0] kb,
    input logic [WORD_SIZE-1:0] s
  );
    return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
  endfunction

  // The y half uses the freshly updated z of the same round.
  assign z_rnd = z_q - tea_mix(y_q, k2_q, k3_q, sum_q);
  assign y_rnd = y_q - tea_mix(z_rnd, k0_q, k1_q, sum_q);

  assign capture   = (state_q == IDLE) && in_valid;
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign p0        = p0_q;
  assign p1        = p1_q;

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    z_d     = z_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    p0_d    = p0_q;
    p1_d    = p1_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          y_d     = c0;
          z_d     = c1;
          sum_d   = SUM_INIT;
          cnt_d   = CNT_INIT;
          state_d = RUN;
        end
      end
      RUN: begin
        y_d   = y_rnd;
        z_d   = z_rnd;
        sum_d = sum_q - DELTA;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          cnt_d   = cnt_q;
          p0_d    = y_rnd;
          p1_d    = z_rnd;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      y_q     <= '0;
      z_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      p0_q    <= '0;
      p1_q    <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      z_q     <= z_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
    end
  end

  // Key words are only meaningful after a capture, so they carry no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      k0_q <= k0;
      k1_q <= k1;
      k2_q <= k2;
      k3_q <= k3;
    end
  end

endmodule

// File: tb/tb_tea_decipher.sv
// Directed bench for tea_decipher: known zero-key vector, round trips through a TEA encipher model,
// backpressure, ignored inputs while running, asynchronous reset and back-to-back throughput.
module tb_tea_decipher;

  localparam int ROUNDS = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] c0 = '0, c1 = '0;
  logic [31:0] k0 = '0, k1 = '0, k2 = '0, k3 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] p0, p1;
  logic        busy;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  tea_decipher #(.WORD_SIZE(32), .DELTA(32'h9E3779B9), .ROUNDS(ROUNDS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .c0(c0), .c1(c1), .k0(k0), .k1(k1), .k2(k2), .k3(k3),
    .out_valid(out_valid), .out_ready(out_ready), .p0(p0), .p1(p1), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] tea_enc(input logic [31:0] y0, input logic [31:0] z0,
                                          input logic [127:0] k);
    logic [31:0] y, z, s;
    y = y0; z = z0; s = '0;
    for (int r = 0; r < ROUNDS; r++) begin
      s = s + 32'h9E3779B9;
      y = y + (((z << 4) + k[127:96]) ^ (z + s) ^ ((z >> 5) + k[95:64]));
      z = z + (((y << 4) + k[63:32]) ^ (y + s) ^ ((y >> 5) + k[31:0]));
    end
    return {y, z};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h required %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_block(input logic [63:0] c, input logic [127:0] k);
    {c0, c1} = c;
    {k0, k1, k2, k3} = k;
  endtask

  // Captures one block, returns the cycle count from capture edge to out_valid.
  task automatic send_and_wait(input string tag, input logic [63:0] c, input logic [127:0] k,
                               output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    drive_block(c, k);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
    lat = 0;
    while (!out_valid && lat < 100) begin tick(); lat++; end
  endtask

  task automatic round_trip(input string tag, input logic [63:0] pt, input logic [127:0] k);
    int lat;
    send_and_wait(tag, tea_enc(pt[63:32], pt[31:0], k), k, lat);
    chk({tag, "_lat"}, 64'(lat), 64'(ROUNDS));
    chk({tag, "_pt"}, {p0, p1}, pt);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_rel"}, {62'd0, out_valid, in_ready}, 64'b01);
  endtask

  initial begin
    int lat;
    int t_prev;
    logic [63:0] held;
    logic [63:0] pt;
    logic [127:0] key;

    // reset state
    #3;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_p", {p0, p1}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // zero-key known-answer vector
    send_and_wait("kat0", 64'h41EA3A0A_94BAA940, 128'd0, lat);
    chk("kat0_lat", 64'(lat), 64'd32);
    chk("kat0_pt", {p0, p1}, 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("kat0_rel", {62'd0, out_valid, in_ready}, 64'b01);

    // round trips through the encipher model
    round_trip("rt1", 64'h01234567_89ABCDEF, 128'hA56BABCD_0000FFFF_FFFFFFFF_12345678);
    round_trip("rt2", 64'hFFFFFFFF_FFFFFFFF, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF);
    round_trip("rt3", 64'h00000000_00000001, 128'h00000001_00000000_80000000_00000000);
    round_trip("rt4", 64'hDEADBEEF_CAFEF00D, 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0);

    // backpressure: output held, in_valid ignored
    pt  = 64'h13579BDF_2468ACE0;
    key = 128'h11111111_22222222_33333333_44444444;
    send_and_wait("bp", tea_enc(pt[63:32], pt[31:0], key), key, lat);
    held = {p0, p1};
    chk("bp_pt", held, pt);
    in_valid = 1'b1;
    drive_block(64'hAAAAAAAA_55555555, 128'd7);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i % 5 == 4) begin
        chk("bp_hold", {p0, p1}, held);
        chk("bp_flags", {61'd0, out_valid, in_ready, busy}, 64'b100);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_rel", {61'd0, out_valid, in_ready, busy}, 64'b010);
    tick();
    chk("bp_no_queue", {61'd0, out_valid, in_ready, busy}, 64'b010);

    // inputs changed and in_valid pulsed while running
    pt  = 64'h0BADF00D_FEEDFACE;
    key = 128'h9ABCDEF0_12345678_0F0F0F0F_F0F0F0F0;
    drive_block(tea_enc(pt[63:32], pt[31:0], key), key);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    c0 = 32'h12121212;
    k0 = 32'h34343434;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    chk("ign_pt", {p0, p1}, pt);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // asynchronous reset at round 10
    drive_block(64'h41EA3A0A_94BAA940, 128'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_flags", {61'd0, out_valid, in_ready, busy}, 64'b010);
    chk("ar_p", {p0, p1}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar_idle", {61'd0, out_valid, in_ready, busy}, 64'b010);
    round_trip("ar_rt", 64'h76543210_FEDCBA98, 128'h01020304_05060708_090A0B0C_0D0E0F10);

    // back-to-back with out_ready and in_valid held high
    pt  = 64'hC0FFEE00_BAADCAFE;
    key = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    drive_block(tea_enc(pt[63:32], pt[31:0], key), key);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    t_prev = -1;
    for (int b = 0; b < 3; b++) begin
      lat = 0;
      while (!out_valid && lat < 100) begin tick(); lat++; end
      chk("b2b_pt", {p0, p1}, pt);
      if (t_prev >= 0) chk("b2b_period", 64'(cyc - t_prev), 64'(ROUNDS + 2));
      t_prev = cyc;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
